// File: rtl/gf2_reduce_seq.sv
// Multi-cycle GF(2) reducer: folds a 2N-1 bit carry-less product modulo x^N + POLY,
// retiring STEP high-order product bits per cycle behind valid/ready handshakes.
//
// state  | meaning
// IDLE   | waiting for a product, in_ready high
// REDUCE | retiring STEP product bits per cycle from hi downward
// DONE   | out_rem valid, waiting for out_ready
module gf2_reduce_seq #(
  parameter int             N    = 64,
  parameter logic [N-1:0]   POLY = 'h1B,
  parameter int             STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_rem
);

  localparam int            WW     = 2 * N - 1;
  localparam int            HW     = $clog2(2 * N);
  localparam logic [HW-1:0] HI_TOP = HW'(2 * N - 2);
  localparam logic [HW-1:0] N_IDX  = HW'(N);
  localparam logic [HW-1:0] STEP_W = HW'(STEP);
  localparam logic [WW-1:0] MOD    = {{(N - 2){1'b0}}, 1'b1, POLY};

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   w_q, w_d, w_red;
  logic [HW-1:0]   hi_q, hi_d, hi_sub, idx;
  logic [N-1:0]    rem_q, rem_d;

  // Chained conditional XORs: a fold can set lower bits still inside this window.
  always_comb begin : reduce_chain
    w_red = w_q;
    idx   = hi_q;
    for (int k = 0; k < STEP; k++) begin
      idx = hi_q - HW'(k);
      if (idx >= N_IDX && w_red[idx]) begin
        w_red = w_red ^ (MOD << (idx - N_IDX));
      end
    end
  end

  assign hi_sub = hi_q - STEP_W;

  always_comb begin : fsm_next
    state_d = state_q;
    w_d     = w_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_d     = in_prod;
          hi_d    = HI_TOP;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        w_d  = w_red;
        hi_d = hi_sub;
        if (hi_sub < N_IDX) begin
          rem_d   = w_red[N-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      hi_q    <= HI_TOP;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
    end
  end

  // in_ready is held low for as long as reset is asserted.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_rem   = rem_q;

endmodule

// File: tb/tb_gf2_reduce_seq.sv
// Scoreboard bench for gf2_reduce_seq: lane 0 uses STEP=8, lanes 1 and 2 use STEP=1 and STEP=63.
// Expected remainders are queued at accept and checked by a monitor at each output transfer.
module tb_gf2_reduce_seq;

  localparam int           N    = 64;
  localparam logic [63:0]  POLY = 64'h1B;
  localparam logic [126:0] P64  = 127'h1 << 64;
  localparam logic [126:0] P126 = 127'h1 << 126;
  localparam logic [63:0]  E64  = 64'h0000_0000_0000_001B;
  localparam logic [63:0]  E126 = 64'hC000_0000_0000_005A;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2:0]     in_valid;
  logic [2:0]     in_ready;
  logic [2:0]     out_valid;
  logic [2:0]     out_ready = '0;
  logic [126:0]   in_prod [3];
  logic [63:0]    out_rem [3];

  logic           ready_mode;
  logic           ready_manual;

  int             checks = 0;
  int             errors = 0;

  logic [63:0]    q0[$];
  logic [63:0]    q1[$];
  logic [63:0]    q2[$];

  always #5 clk = ~clk;

  gf2_reduce_seq #(.N(N), .POLY(POLY), .STEP(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_rem(out_rem[0])
  );

  gf2_reduce_seq #(.N(N), .POLY(POLY), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_rem(out_rem[1])
  );

  gf2_reduce_seq #(.N(N), .POLY(POLY), .STEP(63)) u_dut_s63 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_prod(in_prod[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_rem(out_rem[2])
  );

  // Long division: each set bit x^i above the field folds into x^(i-64) * POLY.
  function automatic logic [63:0] ref_mod(input logic [126:0] p);
    logic [126:0] w;
    w = p;
    for (int i = 126; i >= 64; i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-64 +: 64] = w[i-64 +: 64] ^ POLY;
      end
    end
    return w[63:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int l, input logic [63:0] v);
    case (l)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_check(input int l, input logic [63:0] act);
    logic [63:0] e;
    bit          have;
    e    = '0;
    have = 1'b0;
    case (l)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output lane%0d: got %h with nothing expected", l, act);
    end else begin
      chk($sformatf("out_rem lane%0d", l), {64'h0, act}, {64'h0, e});
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int l = 0; l < 3; l++) begin
      out_ready[l] = ready_mode ? 1'($urandom_range(0, 1)) : ready_manual;
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst_n && out_valid[l] && out_ready[l]) begin
        pop_check(l, out_rem[l]);
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accept edge.
  task automatic send(input int l, input logic [126:0] p, input logic [63:0] e);
    int t;
    t = 0;
    in_prod[l]  = p;
    in_valid[l] = 1'b1;
    while (!in_ready[l] && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (in_ready[l]) begin
      @(posedge clk); #1;
      push(l, e);
    end else begin
      chk($sformatf("accept_timeout lane%0d", l), 128'(in_ready[l]), 128'h1);
    end
    in_valid[l] = 1'b0;
  endtask

  task automatic wait_valid(input int l, output int cyc);
    cyc = 0;
    while (!out_valid[l] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("valid_timeout lane%0d", l), 128'(out_valid[l]), 128'h1);
  endtask

  task automatic latency_test(input string name, input logic [126:0] p, input logic [63:0] e);
    int cyc;
    cyc = 0;
    ready_manual = 1'b0;
    send(0, p, e);
    while (!out_valid[0] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      chk({name, " in_ready_busy"}, 128'(in_ready[0]), 128'h0);
    end
    chk({name, " latency"}, 128'(cyc), 128'd8);
    ready_manual = 1'b1;
    @(posedge clk); #1;
    ready_manual = 1'b0;
    chk({name, " out_valid_after_xfer"}, 128'(out_valid[0]), 128'h0);
    chk({name, " in_ready_after_xfer"}, 128'(in_ready[0]), 128'h1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 8000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", 128'(q0.size() + q1.size() + q2.size()), 128'h0);
  endtask

  initial begin
    int             cyc;
    logic [127:0]   r;
    logic [126:0]   p;

    rst_n        = 1'b0;
    in_valid     = '0;
    ready_mode   = 1'b0;
    ready_manual = 1'b0;
    for (int l = 0; l < 3; l++) in_prod[l] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 128'(out_valid), 128'h0);
    chk("reset in_ready", 128'(in_ready), 128'h0);
    chk("reset out_rem", {64'h0, out_rem[0]}, 128'h0);
    rst_n = 1'b1;
    #1;
    chk("release in_ready", 128'(in_ready), 128'h7);

    latency_test("single_term", P64, E64);
    latency_test("high_term", P126, E126);
    latency_test("passthrough", 127'h1234, 64'h1234);

    // Backpressure with a second product already offered.
    send(0, P126, E126);
    wait_valid(0, cyc);
    chk("bp latency", 128'(cyc), 128'd8);
    in_prod[0]  = P64;
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp out_valid_held", 128'(out_valid[0]), 128'h1);
      chk("bp in_ready_low", 128'(in_ready[0]), 128'h0);
      chk("bp out_rem_stable", {64'h0, out_rem[0]}, {64'h0, E126});
    end
    ready_manual = 1'b1;
    @(posedge clk); #1;
    ready_manual = 1'b0;
    chk("bp in_ready_after_F", 128'(in_ready[0]), 128'h1);
    chk("bp out_valid_after_F", 128'(out_valid[0]), 128'h0);
    @(posedge clk); #1;
    push(0, E64);
    in_valid[0] = 1'b0;
    chk("bp accepted_F+1", 128'(in_ready[0]), 128'h0);
    ready_manual = 1'b1;
    wait_valid(0, cyc);
    @(posedge clk); #1;
    ready_manual = 1'b0;
    drain();

    // Reset landing on the third REDUCE edge.
    send(0, P126 | 127'h5555, ref_mod(P126 | 127'h5555));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst out_valid", 128'(out_valid[0]), 128'h0);
    chk("midrst out_rem", {64'h0, out_rem[0]}, 128'h0);
    chk("midrst in_ready", 128'(in_ready[0]), 128'h0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready_release", 128'(in_ready[0]), 128'h1);
    ready_manual = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst no_stale_valid", 128'(out_valid[0]), 128'h0);
    end
    send(0, P64, E64);
    wait_valid(0, cyc);
    @(posedge clk); #1;
    ready_manual = 1'b0;
    drain();

    // Random products with random backpressure on every lane.
    ready_mode = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int n = 0; n < ((l == 0) ? 1000 : 150); n++) begin
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        p = r[126:0];
        case (n % 4)
          1: p = p & {63'h0, {64{1'b1}}};
          2: p = p & ({127{1'b1}} << 120);
          default: ;
        endcase
        if (n == 0) p = {127{1'b1}};
        if (n == 1) p = '0;
        send(l, p, ref_mod(p));
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
